edf_ic_nested: RTL

Second-generation earliest-deadline-first interrupt controller. Per-source relative deadlines are converted to absolute timestamps on the rising edge of each request. A registered min-deadline arbiter selects the winner, gated by enables and by EDF preemption against in-service deadlines. Sits between peripheral IRQ lines and the core, with a claim handshake on the core side and a memory-mapped config/complete interface on the bus side.

---
 rtl/edf_ic_pkg.sv | 17 +
 rtl/edf_gw_cell.sv | 46 ++++
 rtl/edf_ic_nested.sv | 134 +++++++++++++
 3 files changed

// File: rtl/edf_ic_pkg.sv
// edf_ic_pkg: register offsets and the wrap-safe deadline compare shared by the EDF interrupt controller.
package edf_ic_pkg;

    localparam logic [31:0] REL_DL_BASE    = 32'h000;
    localparam logic [31:0] ENABLE_OFF     = 32'h100;
    localparam logic [31:0] PENDING_OFF    = 32'h104;
    localparam logic [31:0] IN_SERVICE_OFF = 32'h108;
    localparam logic [31:0] COMPLETE_OFF   = 32'h10C;

    // a is earlier than b when (a - b) mod 2^w is negative; zero-extended operands keep the low w bits exact
    function automatic logic dl_before(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
        logic [63:0] d;
        d = a - b;
        return d[w-1];
    endfunction

endpackage

// File: rtl/edf_gw_cell.sv
// edf_gw_cell: per-source gateway - rising-edge capture of an absolute deadline, pending and in-service flags.
module edf_gw_cell #(
    parameter int TsWidth = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               irq_i,
    input  logic [TsWidth-1:0] mtime_i,
    input  logic [TsWidth-1:0] rel_dl_i,
    input  logic               claim_i,
    input  logic               complete_i,
    output logic               pending_o,
    output logic               in_service_o,
    output logic [TsWidth-1:0] abs_dl_o
);

    logic               r_irq_q;
    logic               r_pending;
    logic               r_in_service;
    logic [TsWidth-1:0] r_abs_dl;
    logic               w_edge;
    logic               w_cap;

    assign w_edge = irq_i & ~r_irq_q;
    // an edge coalesces into an existing request unless that request is being claimed right now
    assign w_cap  = w_edge & (~r_pending | claim_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_q      <= 1'b0;
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
            r_abs_dl     <= '1;
        end else begin
            r_irq_q      <= irq_i;
            r_pending    <= w_cap | (r_pending & ~claim_i);
            r_in_service <= claim_i | (r_in_service & ~complete_i);
            if (w_cap) r_abs_dl <= mtime_i + rel_dl_i;
        end
    end

    assign pending_o    = r_pending;
    assign in_service_o = r_in_service;
    assign abs_dl_o     = r_abs_dl;

endmodule

// File: rtl/edf_ic_nested.sv
// edf_ic_nested: earliest-deadline-first interrupt controller with nested preemption,
// claim handshake toward the core and a memory-mapped config/complete window.
module edf_ic_nested
    import edf_ic_pkg::*;
#(
    parameter int          NrIrqs   = 8,
    parameter int          TsWidth  = 64,
    parameter logic [31:0] BaseAddr = '0,
    localparam int         IdWidth  = $clog2(NrIrqs)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [31:0]        cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic [63:0]        mtime_i,
    input  logic [NrIrqs-1:0]  irq_i,
    output logic [IdWidth-1:0] irq_id_o,
    output logic [TsWidth-1:0] irq_dl_o,
    output logic               irq_valid_o,
    input  logic               irq_ready_i
);

    logic [31:0]        r_rel_dl [NrIrqs];
    logic [NrIrqs-1:0]  r_enable;
    logic [31:0]        r_rdata;
    logic [IdWidth-1:0] r_id;
    logic [TsWidth-1:0] r_dl;
    logic               r_valid;

    logic [31:0]        w_off;
    logic [31:0]        w_rel_off;
    logic               w_rel_hit;
    logic [IdWidth-1:0] w_rel_idx;
    logic               w_wr;
    logic [IdWidth-1:0] w_cpl_id;
    logic               w_cpl;
    logic               w_claim;
    logic [31:0]        w_rdata;
    logic [NrIrqs-1:0]  w_pending;
    logic [NrIrqs-1:0]  w_in_service;
    logic [NrIrqs-1:0]  w_cand;
    logic [TsWidth-1:0] w_abs [NrIrqs];

    // arbiter chains: index i holds the best result over sources 0..i-1
    logic [NrIrqs:0]    w_cv;
    logic [IdWidth-1:0] w_cid [NrIrqs+1];
    logic [TsWidth-1:0] w_cdl [NrIrqs+1];
    logic [NrIrqs:0]    w_sv;
    logic [TsWidth-1:0] w_sdl [NrIrqs+1];

    assign w_off     = cfg_addr_i - BaseAddr;
    assign w_rel_off = w_off - REL_DL_BASE;
    assign w_rel_hit = (w_rel_off < 32'(4 * NrIrqs)) && (w_rel_off[1:0] == 2'b00);
    assign w_rel_idx = w_rel_off[IdWidth+1:2];
    assign w_wr      = cfg_req_i & cfg_we_i;
    assign w_cpl_id  = cfg_wdata_i[IdWidth-1:0];
    assign w_cpl     = w_wr && (w_off == COMPLETE_OFF) && (32'(w_cpl_id) < 32'(NrIrqs));
    assign w_claim   = r_valid & irq_ready_i;
    assign w_cand    = w_pending & r_enable & ~w_in_service;

    assign w_rdata = w_rel_hit                  ? r_rel_dl[w_rel_idx] :
                     (w_off == ENABLE_OFF)      ? 32'(r_enable) :
                     (w_off == PENDING_OFF)     ? 32'(w_pending) :
                     (w_off == IN_SERVICE_OFF)  ? 32'(w_in_service) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rel_dl <= '{default: '0};
            r_enable <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_wr && w_rel_hit) r_rel_dl[w_rel_idx] <= cfg_wdata_i;
            if (w_wr && w_off == ENABLE_OFF) r_enable <= cfg_wdata_i[NrIrqs-1:0];
            r_rdata <= (cfg_req_i && !cfg_we_i) ? w_rdata : '0;
        end
    end

    assign w_cv[0]  = 1'b0;
    assign w_cid[0] = '0;
    assign w_cdl[0] = '1;
    assign w_sv[0]  = 1'b0;
    assign w_sdl[0] = '1;

    for (genvar i = 0; i < NrIrqs; i++) begin : g_src
        logic w_take;
        logic w_stake;

        edf_gw_cell #(.TsWidth(TsWidth)) u_cell (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .irq_i        (irq_i[i]),
            .mtime_i      (mtime_i[TsWidth-1:0]),
            .rel_dl_i     (TsWidth'(r_rel_dl[i])),
            .claim_i      (w_claim && r_id == IdWidth'(i)),
            .complete_i   (w_cpl && w_cpl_id == IdWidth'(i)),
            .pending_o    (w_pending[i]),
            .in_service_o (w_in_service[i]),
            .abs_dl_o     (w_abs[i])
        );

        // strict compare keeps the lower ID on equal deadlines
        assign w_take    = w_cand[i] & (~w_cv[i] | dl_before(64'(w_abs[i]), 64'(w_cdl[i]), TsWidth));
        assign w_cv[i+1] = w_cv[i] | w_cand[i];
        assign w_cid[i+1] = w_take ? IdWidth'(i) : w_cid[i];
        assign w_cdl[i+1] = w_take ? w_abs[i] : w_cdl[i];

        assign w_stake    = w_in_service[i] & (~w_sv[i] | dl_before(64'(w_abs[i]), 64'(w_sdl[i]), TsWidth));
        assign w_sv[i+1]  = w_sv[i] | w_in_service[i];
        assign w_sdl[i+1] = w_stake ? w_abs[i] : w_sdl[i];
    end

    // a claim masks valid for one cycle so the claimed source is never re-presented from stale state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id    <= '0;
            r_dl    <= '1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_cv[NrIrqs] && !w_claim &&
                       (!w_sv[NrIrqs] || dl_before(64'(w_cdl[NrIrqs]), 64'(w_sdl[NrIrqs]), TsWidth));
            r_dl    <= w_cv[NrIrqs] ? w_cdl[NrIrqs] : '1;
            if (w_cv[NrIrqs]) r_id <= w_cid[NrIrqs];
        end
    end

    assign cfg_rdata_o = r_rdata;
    assign irq_id_o    = r_id;
    assign irq_dl_o    = r_dl;
    assign irq_valid_o = r_valid;

endmodule
